// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// the single-cycle/iterative opcode classifier.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
  localparam logic [3:0] OP_RSV   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide,
// one step per cycle, sharing the same hi/lo working registers.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Multiply: hi accumulates, lo holds the multiplier.
  // Divide: hi is the remainder, lo shifts the dividend out and the quotient in.
  logic [WIDTH-1:0] hi_reg, lo_reg, opnd_reg;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [CW-1:0]    count_reg;
  logic             div_reg, high_reg;
  logic [WIDTH:0]   mul_sum, div_shift;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    if (div_reg) begin
      // A zero divisor always "fits", giving all-ones quotient and remainder = a.
      if (div_shift >= {1'b0, opnd_reg}) begin
        hi_next = div_shift[WIDTH-1:0] - opnd_reg;
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {mul_sum, lo_reg[WIDTH-1:1]};
    end
  end

  // Result reflects the step in progress so the caller can register it on the final edge.
  assign result = high_reg ? hi_next : lo_next;
  assign last   = (count_reg == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      opnd_reg  <= '0;
      count_reg <= '0;
      div_reg   <= 1'b0;
      high_reg  <= 1'b0;
    end else if (load) begin
      div_reg   <= (op == OP_DIVU) || (op == OP_REMU);
      high_reg  <= (op == OP_MULHU) || (op == OP_REMU);
      hi_reg    <= '0;
      lo_reg    <= ((op == OP_DIVU) || (op == OP_REMU)) ? a : b;
      opnd_reg  <= ((op == OP_DIVU) || (op == OP_REMU)) ? b : a;
      count_reg <= CW'(WIDTH);
    end else if (step && (count_reg != '0)) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish on the accept edge, multiply and
// divide run WIDTH steps in alu_iter; result held until the next done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf
);

  state_t           state_reg, state_next;
  logic             iter_load, iter_step, iter_last;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] comb_out;
  logic             comb_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_out_reg;
  logic             zero_reg, ovf_reg;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = b[SHW-1:0];

  always_comb begin
    comb_out = '0;
    comb_ovf = 1'b0;
    case (alu_control)
      OP_AND:  comb_out = a & b;
      OP_OR:   comb_out = a | b;
      OP_XOR:  comb_out = a ^ b;
      OP_NOR:  comb_out = ~(a | b);
      OP_ADD: begin
        comb_out = sum;
        comb_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        comb_out = diff;
        comb_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  comb_out = a << sh;
      OP_SRL:  comb_out = a >> sh;
      OP_SRA:  comb_out = $unsigned($signed(a) >>> sh);
      OP_SLTU: comb_out = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  comb_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: comb_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    iter_load  = 1'b0;
    iter_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          iter_load  = is_iterative(alu_control);
          state_next = is_iterative(alu_control) ? RUN : DONE;
        end
      end
      RUN: begin
        iter_step = 1'b1;
        if (iter_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs move only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_reg <= '0;
      zero_reg    <= 1'b1;
      ovf_reg     <= 1'b0;
    end else if ((state_reg == IDLE) && start && !is_iterative(alu_control)) begin
      alu_out_reg <= comb_out;
      zero_reg    <= (comb_out == '0);
      ovf_reg     <= comb_ovf;
    end else if ((state_reg == RUN) && iter_last) begin
      alu_out_reg <= iter_result;
      zero_reg    <= (iter_result == '0);
      ovf_reg     <= 1'b0;
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (iter_load),
    .step   (iter_step),
    .op     (alu_control),
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .result (iter_result)
  );

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign alu_out = alu_out_reg;
  assign zero    = zero_reg;
  assign ovf     = ovf_reg;

endmodule
